// File: rtl/cp_pkg.sv
// cp_pkg: shared widths and state encoding for the cyclic-prefix sequencer
package cp_pkg;
    localparam int SAMPLE_W      = 16;
    localparam int IN_W          = 128;
    localparam int SYM_W         = 304;
    localparam int WORDS_PER_SYM = 19;
    localparam int CP_W          = SYM_W - 2 * IN_W;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
endpackage

// File: rtl/cyclic_prefix_256.sv
// cyclic_prefix_256: prepends the last three samples of the {phase, quad} body as the prefix
module cyclic_prefix_256
    import cp_pkg::*;
(
    input  logic [IN_W-1:0]  phase,
    input  logic [IN_W-1:0]  quad,
    output logic [SYM_W-1:0] symbol_out
);
    logic [2*IN_W-1:0] body;
    assign body       = {phase, quad};
    assign symbol_out = {body[CP_W-1:0], body};
endmodule

// File: rtl/cp_symbol_sequencer.sv
// cp_symbol_sequencer: loads one symbol, prefixes it and streams 19 words with frame counting
module cp_symbol_sequencer
    import cp_pkg::*;
#(
    parameter int SYMS_PER_FRAME = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_phase,
    input  logic [IN_W-1:0]     in_quad,
    input  logic                frame_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_sop,
    output logic                out_eop,
    output logic                out_frame_last,
    output logic [7:0]          sym_count,
    output logic                busy
);
    localparam logic [7:0] LAST_SYM  = 8'(SYMS_PER_FRAME - 1);
    localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_SYM - 1);
    state_t           state;
    logic [IN_W-1:0]  phase_q, quad_q;
    logic [SYM_W-1:0] sym_q, symbol_out;
    logic [4:0]       word_idx;
    logic             last_xfer;
    cyclic_prefix_256 u_cp (
        .phase      (phase_q),
        .quad       (quad_q),
        .symbol_out (symbol_out)
    );
    assign in_ready       = state == IDLE;
    assign out_valid      = state == STREAM;
    assign busy           = state != IDLE;
    assign out_data       = sym_q[SYM_W-1 -: SAMPLE_W];
    assign out_sop        = out_valid && word_idx == 5'd0;
    assign out_eop        = out_valid && word_idx == LAST_WORD;
    assign out_frame_last = out_eop && sym_count == LAST_SYM;
    assign last_xfer      = out_eop && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_q   <= '0;
            quad_q    <= '0;
            sym_q     <= '0;
            word_idx  <= '0;
            sym_count <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    phase_q <= in_phase;
                    quad_q  <= in_quad;
                    state   <= LOAD;
                end
                LOAD: begin
                    sym_q    <= symbol_out;
                    word_idx <= '0;
                    state    <= STREAM;
                end
                STREAM: if (out_ready) begin
                    sym_q    <= sym_q << SAMPLE_W;
                    word_idx <= word_idx + 5'd1;
                    if (word_idx == LAST_WORD) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // clear wins over a coincident end-of-symbol increment
            if (frame_clr) sym_count <= '0;
            else if (last_xfer) sym_count <= sym_count == LAST_SYM ? 8'd0 : sym_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_cp_symbol_sequencer.sv
// tb_cp_symbol_sequencer: directed checks of latency, word order, backpressure, framing and reset abort
module tb_cp_symbol_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_phase = '0;
    logic [127:0] in_quad = '0;
    logic         frame_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic         out_sop, out_eop, out_frame_last;
    logic [7:0]   sym_count;
    logic         busy;
    int           n_checks = 0;
    int           n_pass = 0;
    int           exp_cnt = 0;

    cp_symbol_sequencer #(.SYMS_PER_FRAME(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_phase       (in_phase),
        .in_quad        (in_quad),
        .frame_clr      (frame_clr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_frame_last (out_frame_last),
        .sym_count      (sym_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic logic [127:0] pat(input int s);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'(s * 8 + j + 1);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the symbol
    task automatic run_symbol(input logic [127:0] ph, input logic [127:0] qd, input int stall_at,
                              input int stall_len, input bit clr_eop, input int abort_at);
        logic [303:0] exp_sym;
        int hold;
        exp_sym = {qd[47:0], ph, qd};
        check("idle_ready", {31'd0, in_ready}, 1);
        in_phase = ph;
        in_quad = qd;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("load_ready", {31'd0, in_ready}, 0);
        check("load_valid", {31'd0, out_valid}, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 19; k++) begin
            hold = (k == stall_at) ? stall_len : 0;
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                check($sformatf("w%0d_valid", k), {31'd0, out_valid}, 1);
                check($sformatf("w%0d_data", k), {16'd0, out_data}, {16'd0, exp_sym[303-16*k -: 16]});
                check($sformatf("w%0d_sop", k), {31'd0, out_sop}, {31'd0, k == 0});
                check($sformatf("w%0d_eop", k), {31'd0, out_eop}, {31'd0, k == 18});
                check($sformatf("w%0d_flast", k), {31'd0, out_frame_last}, {31'd0, k == 18 && exp_cnt == 15});
                check($sformatf("w%0d_inrdy", k), {31'd0, in_ready}, 0);
                check($sformatf("w%0d_cnt", k), {24'd0, sym_count}, exp_cnt);
                if (k == abort_at) begin
                    rst_n = 1'b0;
                    in_valid = 1'b0;
                    #1;
                    check("abort_valid", {31'd0, out_valid}, 0);
                    check("abort_busy", {31'd0, busy}, 0);
                    check("abort_cnt", {24'd0, sym_count}, 0);
                    exp_cnt = 0;
                    return;
                end
                out_ready = (h == hold);
                frame_clr = clr_eop && k == 18 && h == hold;
            end
        end
        @(negedge clk);
        frame_clr = 1'b0;
        in_valid = 1'b0;
        exp_cnt = clr_eop ? 0 : (exp_cnt == 15 ? 0 : exp_cnt + 1);
        check("end_valid", {31'd0, out_valid}, 0);
        check("end_busy", {31'd0, busy}, 0);
        check("end_cnt", {24'd0, sym_count}, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 1);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_cnt", {24'd0, sym_count}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_data", {16'd0, out_data}, 0);
        check("rst_flags", {29'd0, out_sop, out_eop, out_frame_last}, 0);
        run_symbol({8{16'h000a}}, {8{16'h0014}}, -1, 0, 1'b0, -1);
        run_symbol(pat(1), pat(2), 7, 5, 1'b0, -1);
        frame_clr = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        exp_cnt = 0;
        check("clr_idle_cnt", {24'd0, sym_count}, 0);
        for (int s = 0; s < 16; s++) run_symbol(pat(3 + s), pat(40 + s), -1, 0, 1'b0, -1);
        check("frame_wrap", exp_cnt, 0);
        for (int s = 0; s < 6; s++) run_symbol(pat(60 + s), pat(70 + s), -1, 0, s == 5, -1);
        run_symbol(pat(80), pat(81), -1, 0, 1'b0, -1);
        run_symbol(pat(82), pat(83), -1, 0, 1'b0, 10);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cnt", {24'd0, sym_count}, 0);
        run_symbol(pat(90), pat(91), -1, 0, 1'b0, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cp_symbol_sequencer.md
# cp_symbol_sequencer

Sequencing controller for the cyclic-prefix stage of the OFDM transmit chain. It accepts one OFDM symbol per handshake: 128-bit in-phase and 128-bit quadrature vectors, each 8 × 16-bit samples. It drives an internal cyclic_prefix_256 instance with those vectors and captures the resulting 304-bit prefixed symbol. It then streams the symbol to the DAC/framing interface as 19 × 16-bit words with valid/ready backpressure, and counts symbols to mark frame boundaries.

## Interface
Parameters:
- SYMS_PER_FRAME, 16: symbols per frame; range 1..256.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  symbol offered.
- in_ready  output  1  sequencer can accept a symbol.
- in_phase  input  128  in-phase samples, fed to cyclic_prefix_256 .phase.
- in_quad  input  128  quadrature samples, fed to cyclic_prefix_256 .quad.
- frame_clr  input  1  synchronous pulse; zeroes the symbol counter.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  16  prefixed-symbol word.
- out_sop  output  1  first word (word 0) of a symbol.
- out_eop  output  1  last word (word 18) of a symbol.
- out_frame_last  output  1  out_eop of symbol SYMS_PER_FRAME-1.
- sym_count  output  8  index of the symbol currently or next streamed, 0..SYMS_PER_FRAME-1.
- busy  output  1  state != IDLE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_phase/in_quad into phase_q/quad_q and go to LOAD.
  - LOAD: one cycle. The cyclic_prefix_256 output, driven from phase_q/quad_q, settles. At the edge, capture symbol_out into a 304-bit shift register sym_q, clear word_idx to 0, go to STREAM.
  - STREAM: out_valid=1 and out_data=sym_q[303:288]. On each out_valid&&out_ready: shift sym_q left 16 bits and increment word_idx. On the transfer with word_idx==18, go to IDLE.
- Word order: word k = symbol_out[303-16k : 288-16k], MSB first.
- Flags (combinational from state/word_idx/sym_count):
  - out_sop = STREAM && word_idx==0.
  - out_eop = STREAM && word_idx==18.
  - out_frame_last = out_eop && sym_count==SYMS_PER_FRAME-1.
- Symbol counter: increments on the word-18 transfer and wraps SYMS_PER_FRAME-1 → 0.
  - frame_clr sets it to 0 and has priority over a simultaneous increment.
  - frame_clr does not interrupt streaming.
- in_ready is 0 in LOAD and STREAM. There is no overlap between consecutive symbols.
- in_valid while not ready is ignored; the source must hold it.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_sop/out_eop/out_frame_last=0, sym_count=0, busy=0, sym_q/phase_q/quad_q=0.
- Reset asserted mid-symbol aborts immediately: out_valid drops asynchronously and the partial symbol is discarded.
- Latency: handshake in cycle 0, then LOAD in cycle 1, then word 0 valid in cycle 2. With out_ready held high, word 18 is in cycle 20 and IDLE is in cycle 21. Minimum symbol period is 21 cycles.
- Backpressure: while out_valid && !out_ready, out_data, out_sop, out_eop, out_frame_last and sym_count hold stable. out_valid never deasserts before its transfer.
- out_ready is a don't-care outside STREAM.

## Structure
- Shared package cp_pkg:
  - SAMPLE_W=16, IN_W=128, SYM_W=304, WORDS_PER_SYM=19.
  - State enum {IDLE, LOAD, STREAM}.
  - cyclic_prefix_256 must use IN_W/SYM_W from this package.
- One sub-module: the existing combinational cyclic_prefix_256, instantiated as u_cp. The sequencer adds no logic in the combinational path.
- word_idx is 5 bits; sym_count is 8 bits, compared against SYMS_PER_FRAME-1.

## Test plan
- Reset check: after release, in_ready=1, out_valid=0, sym_count=0, busy=0.
- Single symbol: apply phase=128'h000a…000a, quad=128'h0014…0014 with out_ready=1.
  - 19 words appear in cycles 2..20.
  - out_sop on word 0 only, out_eop on word 18 only.
  - Words equal the 16-bit slices of a standalone cyclic_prefix_256 output for the same input.
  - sym_count becomes 1.
- Backpressure: drop out_ready for 5 cycles at word 7. Word 7 holds stable for those 5 cycles; the total stream is 19 words with none lost or duplicated.
- Frame: 16 back-to-back symbols with SYMS_PER_FRAME=16.
  - out_frame_last pulses only on the 16th out_eop.
  - sym_count wraps 15→0.
  - No transfer occurs while in_ready=0.
- frame_clr coincident with the word-18 transfer of symbol 5: sym_count becomes 0, not 6.
- Reset mid-stream at word 10: out_valid goes 0 at once. After release, a new symbol streams a full 19 words starting with sop, and sym_count=0.
